// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//
// Multi-channel LED driver. Each of N_CH channels runs its own pattern:
// OFF, STEADY, continuous BLINK or a counted BURST of blink periods. Period,
// duty and burst count are programmed per channel through one write port.
// All channels count time in ticks from a single shared prescaler. A global
// enable masks the LED outputs without disturbing any counter.
//
// Writes land in a per-channel shadow register. The shadow is copied into the
// active configuration either immediately, when the channel is OFF, or at the
// channel's next period boundary. A running pattern therefore never shows a
// torn period.
//
// Ports
//   i_clock       single clock, rising edge
//   i_reset_n     synchronous active-low reset
//   i_enable      global LED gate (combinational on o_led only)
//   i_cfg_valid   write strobe, one write per asserted cycle
//   i_cfg_ch      target channel; indices >= N_CH are ignored
//   i_cfg_mode    00 OFF, 01 STEADY, 10 BLINK, 11 BURST
//   i_cfg_period  period in ticks (0 behaves as 1)
//   i_cfg_duty    high ticks per period
//   i_cfg_count   number of periods in BURST mode
//   o_led         LED drives
//   o_busy        channel active or holding a pending write
//   o_done        one-clock pulse when a burst finishes
module led_pattern_gen #(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = 125,
  parameter int PER_W    = 16,
  parameter int CNT_W    = 8,
  parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_cfg_valid,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [1:0]       i_cfg_mode,
  input  logic [PER_W-1:0] i_cfg_period,
  input  logic [PER_W-1:0] i_cfg_duty,
  input  logic [CNT_W-1:0] i_cfg_count,
  output logic [N_CH-1:0]  o_led,
  output logic [N_CH-1:0]  o_busy,
  output logic [N_CH-1:0]  o_done
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STEADY = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_BURST  = 2'b11
  } mode_t;

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Shared prescaler. With TICK_DIV == 1 the count stays at 0 and every
  // clock is a tick.
  logic [PS_W-1:0] presc;
  logic            tick;

  assign tick = (presc == PS_W'(TICK_DIV - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Periods are held as P-1, so the boundary compare needs no subtraction.
  // A programmed period of 0 maps to P-1 = 0, the same as a period of 1.
  logic [PER_W-1:0] cfg_pm1;

  assign cfg_pm1 = (i_cfg_period == '0) ? '0 : (i_cfg_period - 1'b1);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    mode_t            sh_mode;
    logic [PER_W-1:0] sh_pm1;
    logic [PER_W-1:0] sh_duty;
    logic [CNT_W-1:0] sh_count;
    logic             pending;

    mode_t            act_mode;
    logic [PER_W-1:0] act_pm1;
    logic [PER_W-1:0] act_duty;
    logic [PER_W-1:0] ph;
    logic [CNT_W-1:0] rem;
    logic             done;

    logic             hit;
    logic             boundary;
    logic             load_wr;
    logic             load_sh;
    logic             raw;

    mode_t            new_mode;
    logic [PER_W-1:0] new_pm1;
    logic [PER_W-1:0] new_duty;
    logic [CNT_W-1:0] new_count;

    assign hit      = i_cfg_valid && (i_cfg_ch == CH_W'(gi));
    assign boundary = tick && (act_mode != MODE_OFF) && (ph == act_pm1);

    // A write to an idle channel, or one that lands on the boundary cycle,
    // goes straight to the active set. Otherwise the shadow transfers at the
    // boundary, if it holds anything.
    assign load_wr  = hit && ((act_mode == MODE_OFF) || boundary);
    assign load_sh  = !load_wr && pending && boundary;

    always_comb begin
      if (load_wr) begin
        new_mode  = mode_t'(i_cfg_mode);
        new_pm1   = cfg_pm1;
        new_duty  = i_cfg_duty;
        new_count = i_cfg_count;
      end else begin
        new_mode  = sh_mode;
        new_pm1   = sh_pm1;
        new_duty  = sh_duty;
        new_count = sh_count;
      end
    end

    always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
        sh_mode  <= MODE_OFF;
        sh_pm1   <= '0;
        sh_duty  <= '0;
        sh_count <= '0;
        pending  <= 1'b0;
        act_mode <= MODE_OFF;
        act_pm1  <= '0;
        act_duty <= '0;
        ph       <= '0;
        rem      <= '0;
        done     <= 1'b0;
      end else begin
        done <= 1'b0;

        if (hit && !load_wr) begin
          sh_mode  <= mode_t'(i_cfg_mode);
          sh_pm1   <= cfg_pm1;
          sh_duty  <= i_cfg_duty;
          sh_count <= i_cfg_count;
          pending  <= 1'b1;
        end

        if (load_wr || load_sh) begin
          pending  <= 1'b0;
          act_pm1  <= new_pm1;
          act_duty <= new_duty;
          ph       <= '0;
          rem      <= new_count;
          // An empty burst completes on the spot without lighting the LED.
          if ((new_mode == MODE_BURST) && (new_count == '0)) begin
            act_mode <= MODE_OFF;
            done     <= 1'b1;
          end else begin
            act_mode <= new_mode;
          end
        end else if (act_mode == MODE_OFF) begin
          ph <= '0;
        end else if (tick) begin
          if (boundary) begin
            ph <= '0;
            if (act_mode == MODE_BURST) begin
              if (rem == CNT_W'(1)) begin
                act_mode <= MODE_OFF;
                done     <= 1'b1;
              end else begin
                rem <= rem - 1'b1;
              end
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
      end
    end

    always_comb begin
      case (act_mode)
        MODE_STEADY: raw = 1'b1;
        MODE_BLINK:  raw = (ph < act_duty);
        MODE_BURST:  raw = (ph < act_duty);
        default:     raw = 1'b0;
      endcase
    end

    assign o_led[gi]  = raw & i_enable;
    assign o_busy[gi] = pending | (act_mode != MODE_OFF);
    assign o_done[gi] = done;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed testbench for led_pattern_gen with N_CH=2 and TICK_DIV=4.
// CH_W is widened to 2 so that an out-of-range channel index can be driven.
// Inputs change on the falling edge. Outputs are sampled 1 time unit after
// the falling edge.
module tb_led_pattern_gen;
  localparam int N_CH     = 2;
  localparam int TICK_DIV = 4;
  localparam int PER_W    = 16;
  localparam int CNT_W    = 8;
  localparam int CH_W     = 2;

  localparam logic [1:0] M_OFF    = 2'b00;
  localparam logic [1:0] M_STEADY = 2'b01;
  localparam logic [1:0] M_BLINK  = 2'b10;
  localparam logic [1:0] M_BURST  = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [PER_W-1:0] cfg_period = '0;
  logic [PER_W-1:0] cfg_duty = '0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic [N_CH-1:0]  led;
  logic [N_CH-1:0]  busy;
  logic [N_CH-1:0]  done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;   // rising edges since reset release; the tick edges have cyc%4==0
  int base = 0;  // cyc at the channel-0 BLINK start; its boundaries are base+16m

  led_pattern_gen #(
    .N_CH(N_CH), .TICK_DIV(TICK_DIV), .PER_W(PER_W), .CNT_W(CNT_W), .CH_W(CH_W)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_enable(enable),
    .i_cfg_valid(cfg_valid),
    .i_cfg_ch(cfg_ch),
    .i_cfg_mode(cfg_mode),
    .i_cfg_period(cfg_period),
    .i_cfg_duty(cfg_duty),
    .i_cfg_count(cfg_count),
    .o_led(led),
    .o_busy(busy),
    .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Called on a falling edge. The write is sampled on the next rising edge,
  // and the task returns on the falling edge that follows it.
  task automatic write_cfg(input int ch, input logic [1:0] mode, input int per,
                           input int duty, input int cnt);
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_mode   = mode;
    cfg_period = PER_W'(per);
    cfg_duty   = PER_W'(duty);
    cfg_count  = CNT_W'(cnt);
    @(negedge clk);
    cfg_valid  = 1'b0;
    $display("write ch=%0d mode=%0d P=%0d D=%0d count=%0d at cyc=%0d", ch, mode, per, duty, cnt, cyc);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (led !== 2'b00) begin failures++; $display("FAIL reset_led got=%b exp=00", led); end
    checks++; if (busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", busy); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_blink;
    logic [31:0] tr0, tr1;
    logic [1:0]  busy0;
    for (int i = 0; i < 8; i++) begin if ((cyc + 1) % 4 == 0) break; @(negedge clk); end
    write_cfg(0, M_BLINK, 4, 1, 0);
    base = cyc;
    #1;
    busy0 = busy;
    for (int k = 0; k < 32; k++) begin
      if (k != 0) #1;
      tr0[k] = led[0];
      tr1[k] = led[1];
      @(negedge clk);
    end
    checks++; if (busy0 !== 2'b01) begin failures++; $display("FAIL blink_busy got=%b exp=01", busy0); end
    checks++; if (tr0 !== 32'h000F_000F) begin failures++; $display("FAIL blink_led0 got=%h exp=000f000f", tr0); end
    checks++; if (tr1 !== 32'h0) begin failures++; $display("FAIL blink_led1 got=%h exp=00000000", tr1); end
  endtask

  task automatic test_burst;
    logic [31:0] tl, td, tb;
    for (int i = 0; i < 8; i++) begin if ((cyc + 1) % 4 == 0) break; @(negedge clk); end
    write_cfg(1, M_BURST, 2, 1, 3);
    for (int k = 0; k < 32; k++) begin
      #1;
      tl[k] = led[1];
      td[k] = done[1];
      tb[k] = busy[1];
      @(negedge clk);
    end
    checks++; if (tl !== 32'h000F_0F0F) begin failures++; $display("FAIL burst_led got=%h exp=000f0f0f", tl); end
    checks++; if (td !== 32'h0100_0000) begin failures++; $display("FAIL burst_done got=%h exp=01000000", td); end
    checks++; if (tb !== 32'h00FF_FFFF) begin failures++; $display("FAIL burst_busy got=%h exp=00ffffff", tb); end
  endtask

  task automatic test_reconfig;
    logic [47:0] tl, tb;
    for (int i = 0; i < 20; i++) begin if ((cyc - base) % 16 == 4) break; @(negedge clk); end
    write_cfg(0, M_BLINK, 4, 3, 0);
    for (int i = 0; i < 20; i++) begin if ((cyc - base) % 16 == 8) break; @(negedge clk); end
    write_cfg(0, M_BLINK, 4, 2, 0);
    for (int k = 0; k < 48; k++) begin
      #1;
      tl[k] = led[0];
      tb[k] = busy[0];
      @(negedge clk);
    end
    checks++; if (tl !== 48'h7F80_7F80_7F80) begin failures++; $display("FAIL reconfig_led got=%h exp=7f807f807f80", tl); end
    checks++; if (tb !== 48'hFFFF_FFFF_FFFF) begin failures++; $display("FAIL reconfig_busy got=%h exp=ffffffffffff", tb); end
  endtask

  task automatic test_enable;
    logic [19:0] toff;
    logic [15:0] ton;
    for (int i = 0; i < 20; i++) begin if ((cyc - base) % 16 == 0) break; @(negedge clk); end
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      toff[k] = led[0];
      @(negedge clk);
    end
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      ton[k] = led[0];
      @(negedge clk);
    end
    checks++; if (toff !== 20'h0) begin failures++; $display("FAIL enable_off_led got=%h exp=00000", toff); end
    checks++; if (ton !== 16'hF00F) begin failures++; $display("FAIL enable_phase got=%h exp=f00f", ton); end
  endtask

  task automatic test_count_zero;
    logic [7:0] tl, td, tb;
    write_cfg(1, M_BURST, 4, 4, 0);
    for (int k = 0; k < 8; k++) begin
      #1;
      tl[k] = led[1];
      td[k] = done[1];
      tb[k] = busy[1];
      @(negedge clk);
    end
    checks++; if (tl !== 8'h00) begin failures++; $display("FAIL cnt0_led got=%h exp=00", tl); end
    checks++; if (td !== 8'h01) begin failures++; $display("FAIL cnt0_done got=%h exp=01", td); end
    checks++; if (tb !== 8'h00) begin failures++; $display("FAIL cnt0_busy got=%h exp=00", tb); end
  endtask

  task automatic test_invalid_index;
    logic [7:0] tl1, tb1, tb0;
    write_cfg(3, M_STEADY, 4, 4, 5);
    for (int k = 0; k < 8; k++) begin
      #1;
      tl1[k] = led[1];
      tb1[k] = busy[1];
      tb0[k] = busy[0];
      @(negedge clk);
    end
    checks++; if (tl1 !== 8'h00) begin failures++; $display("FAIL badch_led1 got=%h exp=00", tl1); end
    checks++; if (tb1 !== 8'h00) begin failures++; $display("FAIL badch_busy1 got=%h exp=00", tb1); end
    checks++; if (tb0 !== 8'hFF) begin failures++; $display("FAIL badch_busy0 got=%h exp=ff", tb0); end
  endtask

  task automatic test_reset_midburst;
    logic [7:0] td, tb;
    write_cfg(1, M_BURST, 2, 1, 5);
    repeat (6) @(negedge clk);
    #1;
    checks++; if (busy[1] !== 1'b1) begin failures++; $display("FAIL midburst_busy got=%b exp=1", busy[1]); end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (led !== 2'b00) begin failures++; $display("FAIL midrst_led got=%b exp=00", led); end
    checks++; if (busy !== 2'b00) begin failures++; $display("FAIL midrst_busy got=%b exp=00", busy); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL midrst_done got=%b exp=00", done); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      #1;
      td[k] = |done;
      tb[k] = |busy;
      @(negedge clk);
    end
    checks++; if (td !== 8'h00) begin failures++; $display("FAIL postrst_done got=%h exp=00", td); end
    checks++; if (tb !== 8'h00) begin failures++; $display("FAIL postrst_busy got=%h exp=00", tb); end
  endtask

  task automatic test_steady;
    write_cfg(1, M_STEADY, 0, 0, 0);
    #1;
    checks++; if (led !== 2'b10) begin failures++; $display("FAIL steady_led got=%b exp=10", led); end
    checks++; if (busy !== 2'b10) begin failures++; $display("FAIL steady_busy got=%b exp=10", busy); end
    @(negedge clk);
  endtask

  // Channel 1 is STEADY with period 0 (acts as 1), so every tick is a
  // boundary. An OFF write two clocks before a tick applies on that tick.
  task automatic test_back_to_back;
    logic [3:0] tl, tb;
    for (int i = 0; i < 8; i++) begin if (cyc % 4 == 1) break; @(negedge clk); end
    write_cfg(1, M_OFF, 4, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      tl[k] = led[1];
      tb[k] = busy[1];
      @(negedge clk);
    end
    checks++; if (tl !== 4'b0011) begin failures++; $display("FAIL p0_led got=%b exp=0011", tl); end
    checks++; if (tb !== 4'b0011) begin failures++; $display("FAIL p0_busy got=%b exp=0011", tb); end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_reconfig();
    test_enable();
    test_count_zero();
    test_invalid_index();
    test_reset_midburst();
    test_steady();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel LED driver and the parametrised successor to the single-output switch-selected blinker. It provides N_CH independent channels. Each channel has its own mode (off, steady, continuous blink, or counted burst), its own period and its own duty cycle, all programmed through a single write port. Every channel runs off one shared tick prescaler, and a global enable gates all outputs. The block sits between the board's control logic (switch decoder or host register interface) and the LED pins.

## Interface
- N_CH, 4: number of LED channels (≥1).
- TICK_DIV, 125: clocks per tick (≥1). All periods and duties are counted in ticks.
- PER_W, 16: width of the period, duty and phase fields.
- CNT_W, 8: width of the burst count.
- CH_W, max(1,$clog2(N_CH)): width of the channel index.
- i_clock  in  1  the single clock; all logic on its rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_enable  in  1  global output gate; gates outputs only, never counters.
- i_cfg_valid  in  1  write strobe, one write per asserted cycle. Always accepted, so there is no ready.
- i_cfg_ch  in  CH_W  target channel. A write with an index ≥ N_CH is ignored.
- i_cfg_mode  in  2  00 OFF, 01 STEADY, 10 BLINK, 11 BURST.
- i_cfg_period  in  PER_W  period P in ticks. 0 is treated as 1.
- i_cfg_duty  in  PER_W  ticks high per period, D.
- i_cfg_count  in  CNT_W  number of periods in BURST mode.
- o_led  out  N_CH  LED drives.
- o_busy  out  N_CH  channel active or has a write pending.
- o_done  out  N_CH  one-clock pulse when a burst completes.

## Operation
- **Prescaler.** Free-running counter 0..TICK_DIV-1. `tick` is high for the one clock in which the count equals TICK_DIV-1, then the count wraps to 0.
- **Per-channel registers.** Shadow config with a pending flag, active config, phase counter `ph` (PER_W), remaining count `rem` (CNT_W), and a done flop.
- **Write.** i_cfg_valid loads the shadow of channel i_cfg_ch and sets pending. Multiple writes before a transfer: the last one wins.
- **Transfer (shadow → active).** Loads the active config, sets ph=0, rem=count, and clears pending. It happens:
  - on the edge of the write itself if the channel's active mode is OFF;
  - otherwise at the next period boundary, i.e. the tick on which ph==P-1.
  - A write landing on a boundary cycle for the same channel bypasses the shadow and transfers at that boundary.
- **Phase counter.** In OFF, ph is held at 0. In all other modes, on each tick: ph = (ph==P-1) ? 0 : ph+1.
- **Raw LED value per mode.**
  - OFF: 0.
  - STEADY: 1.
  - BLINK and BURST: (ph < D). D=0 gives always 0; D≥P gives always 1.
- **BURST.** rem decrements at each boundary. At the boundary where rem==1, the active mode becomes OFF and done is set for one clock. A transfer with count=0 makes the channel OFF immediately and pulses done on the next clock, with no LED activity.
- **Outputs.**
  - o_led[c] = raw[c] & i_enable.
  - o_busy[c] = pending[c] | (active mode[c] ≠ OFF).
  - o_done[c] = done flop.
- **Reset.** Prescaler, ph, rem, pending and done are 0. All active and shadow modes are OFF. A reset mid-burst aborts the burst without a done pulse.
- **Arithmetic.** ph compares against P-1 at PER_W bits with no overflow, since P≥1. rem never wraps because it stops at 1.

## Timing
- **Reset values.** o_led=0, o_busy=0, o_done=0 on the clock after i_reset_n is sampled low, and held while it is low.
- **Write to an OFF channel.** The new mode is visible on o_led and o_busy one clock after the i_cfg_valid edge.
- **Write to an active channel.** Takes effect at the next boundary. o_busy stays high throughout.
- **First tick after a transfer** occurs 1..TICK_DIV clocks later, so the first phase is shortened by up to TICK_DIV-1 clocks. After that:
  - full period = P·TICK_DIV clocks;
  - high time = min(D,P)·TICK_DIV clocks.
- **Burst completion.** o_done pulses, o_busy falls and o_led goes 0 all on the same clock, one clock after the final boundary tick.
- **i_enable** is purely combinational on o_led. Toggling it never shifts phase.

## Test plan
- **Continuous blink.** TICK_DIV=4, N_CH=2; write ch0 BLINK, P=4, D=1 → after the first boundary, o_led[0] is high 4 clocks and low 12 clocks repeating; o_led[1]=0; o_busy=01.
- **Burst.** Write ch1 BURST, P=2, D=1, count=3 → exactly three 4-clock high pulses, 8 clocks apart; one-clock o_done[1] with o_busy[1] falling the same clock; no further pulses.
- **Mid-period reconfiguration.** ch0 in BLINK P=4 D=1; write D=3 at phase 1, then D=2 before the boundary → the current period is unchanged; from the next boundary the high time is 8 clocks (the last write wins).
- **Enable gating, count=0 and invalid index.** i_enable low for 20 clocks during BLINK → o_led=0 throughout and the phase is preserved on re-enable. A count=0 BURST write → o_done pulse 1 clock after the write-edge transfer, no LED activity. A write to ch index 3 with N_CH=2 → ignored.
- **Reset mid-burst and STEADY.** Reset mid-burst → all outputs 0 the next clock, no o_done; after release a STEADY write → o_led high 1 clock after the write.
